// File: rtl/bnn_sched_pkg.sv
// -----------------------------------------------------------------------------
// bnn_sched_pkg
// Shared types and constants for the BNN frame scheduler.
//   RES_W             : width of a BNN class result
//   BNN_ERR_CLASS     : class code reported when an inference times out
//   bnn_sched_state_t : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package bnn_sched_pkg;

    localparam int RES_W = 4;

    localparam logic [RES_W-1:0] BNN_ERR_CLASS = 4'hF;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        WAIT_RESULT = 3'd2,
        CLEAR       = 3'd3,
        DELIVER     = 3'd4
    } bnn_sched_state_t;

endpackage

// File: rtl/bnn_sched_watchdog.sv
// -----------------------------------------------------------------------------
// bnn_sched_watchdog
// Cycle counter bounding how long the scheduler waits for a BNN result.
// Only instantiated when BNN_SCHED_WATCHDOG_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the counter (takes priority over cnt_en)
//   cnt_en     : advance the counter by one
//   expired    : counter has reached TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module bnn_sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic cnt_en,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] LAST_COUNT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (cnt_en) begin
            cnt_reg <= cnt_reg + WD_W'(1);
        end
    end

    assign expired = (cnt_reg == LAST_COUNT);

endmodule

// File: rtl/bnn_frame_scheduler.sv
// -----------------------------------------------------------------------------
// bnn_frame_scheduler
// Runs one BNN inference per captured frame: waits for a full image buffer,
// strobes bnn_enable, captures the 4-bit class, strobes bnn_clear together
// with img_consumed, then offers the result downstream on res_valid/res_ready.
//
// Build option: BNN_SCHED_WATCHDOG_EN adds a watchdog that aborts a frame
// after TIMEOUT_CYCLES cycles in WAIT_RESULT (res_data=4'hF, res_err=1) and
// counts timeouts. Without it the scheduler waits forever, res_err and
// timeout_count are tied 0.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sched_en          : allow new frames to start (never aborts a frame)
//   img_buffer_full   : image buffer holds a complete frame
//   img_consumed      : one-cycle pulse releasing the image buffer
//   bnn_enable        : one-cycle launch strobe to bnn_interface
//   bnn_clear         : one-cycle clear strobe to bnn_interface
//   bnn_result_ready  : bnn_interface result valid
//   bnn_result        : bnn_interface class result
//   res_valid/ready   : downstream result handshake
//   res_data, res_err : class (or 4'hF) and timeout flag
//   busy              : FSM not in IDLE
//   frame_count       : delivered results, wrapping
//   timeout_count     : timeouts, saturating at 255
// -----------------------------------------------------------------------------
module bnn_frame_scheduler
    import bnn_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sched_en,
    input  logic             img_buffer_full,
    output logic             img_consumed,
    output logic             bnn_enable,
    output logic             bnn_clear,
    input  logic             bnn_result_ready,
    input  logic [RES_W-1:0] bnn_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             res_err,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       timeout_count
);

    bnn_sched_state_t state_reg, state_next;
    logic [RES_W-1:0] res_data_reg, res_data_next;
    logic [CNT_W-1:0] frame_count_reg;
    logic             wd_expired;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            res_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            res_data_reg <= res_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        res_data_next = res_data_reg;
        case (state_reg)
            IDLE: begin
                if (sched_en && img_buffer_full) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                // A result in the same cycle as expiry takes precedence.
                if (bnn_result_ready) begin
                    res_data_next = bnn_result;
                    state_next    = CLEAR;
                end else if (wd_expired) begin
                    res_data_next = BNN_ERR_CLASS;
                    state_next    = CLEAR;
                end
            end
            CLEAR: begin
                state_next = DELIVER;
            end
            DELIVER: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // All strobes are pure state decodes, so each lasts exactly one state.
    assign bnn_enable   = (state_reg == START);
    assign bnn_clear    = (state_reg == CLEAR);
    assign img_consumed = (state_reg == CLEAR);
    assign res_valid    = (state_reg == DELIVER);
    assign busy         = (state_reg != IDLE);
    assign res_data     = res_data_reg;

    // ------------------------------------------------------ frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_reg <= '0;
        end else if ((state_reg == DELIVER) && res_ready) begin
            frame_count_reg <= frame_count_reg + CNT_W'(1);
        end
    end

    assign frame_count = frame_count_reg;

    // ------------------------------------------------- watchdog / timeouts
`ifdef BNN_SCHED_WATCHDOG_EN
    logic       res_err_reg;
    logic [7:0] timeout_count_reg;

    bnn_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg == START),
        .cnt_en  ((state_reg == WAIT_RESULT) && !bnn_result_ready && !wd_expired),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err_reg       <= 1'b0;
            timeout_count_reg <= '0;
        end else if (state_reg == WAIT_RESULT) begin
            if (bnn_result_ready) begin
                res_err_reg <= 1'b0;
            end else if (wd_expired) begin
                res_err_reg <= 1'b1;
                if (timeout_count_reg != 8'hFF) begin
                    timeout_count_reg <= timeout_count_reg + 8'd1;
                end
            end
        end
    end

    assign res_err       = res_err_reg;
    assign timeout_count = timeout_count_reg;
`else
    // No watchdog: the timeout branch of the FSM can never be taken.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
    assign wd_expired         = 1'b0;
    assign res_err            = 1'b0;
    assign timeout_count      = '0;
`endif

endmodule
